// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: registered one-hot grant with a lock FSM (DEFAULT/GRANTED/LOCKED/LOCK_TAIL).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module ahb_arbiter #(
  parameter int MASTER_NUMBER = 4
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [MASTER_NUMBER-1:0] hbusreq,
  input  logic [MASTER_NUMBER-1:0] hlock,
  input  logic [1:0]               htrans,
  input  logic                     hready,
  output logic [MASTER_NUMBER-1:0] hgrant,
  output logic [3:0]               hmaster,
  output logic                     hmastlock
);

  typedef enum logic [1:0] {DEFAULT, GRANTED, LOCKED, LOCK_TAIL} state_t;

  localparam logic [MASTER_NUMBER-1:0] DEF_GRANT = {1'b1, {(MASTER_NUMBER-1){1'b0}}};
  localparam logic [3:0]               DEF_IDX   = 4'(MASTER_NUMBER-1);

  state_t                   state, next_state;
  logic [MASTER_NUMBER-1:0] next_grant;
  logic [3:0]               grant_idx;
  logic [3:0]               win_idx;
  logic                     any_req;
  logic                     own_locked;
  logic                     take_arb;

  function automatic logic [3:0] lowest_idx(input logic [MASTER_NUMBER-1:0] v);
    logic [3:0] r;
    r = DEF_IDX;
    for (int i = MASTER_NUMBER-1; i >= 0; i--)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  assign any_req    = |hbusreq;
  // Lock is only honoured while the current owner keeps both its request and lock up.
  assign own_locked = |(hbusreq & hlock & hgrant);

  always_comb begin
    grant_idx = DEF_IDX;
    for (int i = 0; i < MASTER_NUMBER; i++)
      if (hgrant[i]) grant_idx = 4'(i);
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [3:0]               rr_ptr;
  logic [MASTER_NUMBER-1:0] rr_mask;

  // Requesters at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < MASTER_NUMBER; i++)
      rr_mask[i] = (4'(i) >= rr_ptr);
    win_idx = (|(hbusreq & rr_mask)) ? lowest_idx(hbusreq & rr_mask) : lowest_idx(hbusreq);
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset)
      rr_ptr <= '0;
    else if (hready && take_arb && any_req)
      rr_ptr <= (win_idx == DEF_IDX) ? 4'd0 : win_idx + 4'd1;
  end
`else
  assign win_idx = lowest_idx(hbusreq);
`endif

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state     <= DEFAULT;
      hgrant    <= DEF_GRANT;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
    end else if (hready) begin
      state     <= next_state;
      hgrant    <= next_grant;
      hmaster   <= grant_idx;
      hmastlock <= (|(hlock & hgrant)) && (htrans != 2'b00);
    end
  end

  always_comb begin
    next_state = state;
    take_arb   = 1'b0;
    case (state)
      DEFAULT, GRANTED: begin
        if (own_locked) next_state = LOCKED;
        else            take_arb   = 1'b1;
      end
      LOCKED:    if (!own_locked) next_state = LOCK_TAIL;
      LOCK_TAIL: take_arb = 1'b1;
      default:   take_arb = 1'b1;
    endcase
    if (take_arb)
      next_state = any_req ? GRANTED : DEFAULT;
  end

  always_comb begin
    next_grant = hgrant;
    if (take_arb) begin
      if (any_req) begin
        for (int i = 0; i < MASTER_NUMBER; i++)
          next_grant[i] = (4'(i) == win_idx);
      end else begin
        next_grant = DEF_GRANT;
      end
    end
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 The block SHALL have parameter MASTER_NUMBER, default 4, legal range 2..16, giving the number of bus masters.
REQ-002 The block SHALL have port hclk, input, 1 bit, the single clock; all registers are clocked on its rising edge.
REQ-003 The block SHALL have port hreset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port hbusreq, input, MASTER_NUMBER bits; bit i is the bus request from master i.
REQ-005 The block SHALL have port hlock, input, MASTER_NUMBER bits; bit i is the locked-transfer request from master i.
REQ-006 The block SHALL have port htrans, input, 2 bits, the transfer type of the current address phase (IDLE=2'b00).
REQ-007 The block SHALL have port hready, input, 1 bit; high means the bus transfer completes this cycle.
REQ-008 The block SHALL have port hgrant, output, MASTER_NUMBER bits, the registered one-hot bus grant.
REQ-009 The block SHALL have port hmaster, output, 4 bits, the index of the master owning the current address phase.
REQ-010 The block SHALL have port hmastlock, output, 1 bit, high when the current address phase is part of a locked sequence.

Function
REQ-011 hgrant SHALL be one-hot in every cycle; zero bits set or multiple bits set is illegal.
REQ-012 hgrant, hmaster, hmastlock and the FSM SHALL update only on rising edges where hready=1 and SHALL hold while hready=0.
REQ-013 Arbitration SHALL be fixed priority: lowest-index requesting master wins; latency SHALL be one cycle from hbusreq sampled to hgrant.
REQ-014 When hbusreq is all zero and hready=1, hgrant SHALL be 1<<(MASTER_NUMBER-1), the default master, on the next cycle.
REQ-015 On a hready=1 edge, hmaster SHALL load the index of the set hgrant bit, and hmastlock SHALL load hlock of that master AND (htrans!=IDLE).
REQ-016 The FSM SHALL have states DEFAULT (default master granted, no requests), GRANTED (a requesting master granted), LOCKED (grant held for a locked sequence) and LOCK_TAIL (one extra held transfer).
REQ-017 Transitions on hready=1 SHALL be as follows: DEFAULT/GRANTED->LOCKED when the granted master has hbusreq=1 and hlock=1; otherwise ->GRANTED if any request, else ->DEFAULT.
REQ-018 While in LOCKED, hgrant SHALL remain unchanged regardless of higher-priority requests; on the first hready=1 edge where the granted master has hlock=0 or hbusreq=0, the FSM SHALL go to LOCK_TAIL.
REQ-019 LOCK_TAIL SHALL hold hgrant for exactly one more hready=1 edge, then re-arbitrate per REQ-017.
REQ-020 A request asserted and withdrawn entirely within hready=0 cycles SHALL have no effect.

Reset
REQ-021 While hreset=0, hgrant SHALL be 1<<(MASTER_NUMBER-1), hmaster SHALL be MASTER_NUMBER-1, hmastlock SHALL be 0, the FSM SHALL be in DEFAULT and the round-robin pointer SHALL be 0, all asynchronously.
REQ-022 Reset asserted mid-LOCKED SHALL abandon the lock immediately with no LOCK_TAIL.
REQ-023 On the first edge after reset release, normal arbitration SHALL apply.

Configuration
REQ-024 When macro ARB_ROUND_ROBIN_EN is defined, arbitration SHALL search from (last granted non-default-grant index + 1) mod MASTER_NUMBER with wrap-around, and the pointer SHALL update only when a requesting master is granted.
REQ-025 When ARB_ROUND_ROBIN_EN is undefined, arbitration SHALL be fixed priority per REQ-013 and the pointer logic SHALL be absent.
REQ-026 Default-master, lock and reset behaviour SHALL be identical in both configurations.

Verification (MASTER_NUMBER=4)
REQ-027 Reset scenario: assert hreset=0 during LOCKED -> hgrant=4'b1000, hmaster=3, hmastlock=0 without waiting for a clock edge.
REQ-028 Priority scenario: hbusreq=4'b0110, hready=1 -> next cycle hgrant=4'b0010; after the following hready=1 edge, hmaster=1.
REQ-029 Default-master scenario: hbusreq=4'b0000, hready=1 -> next cycle hgrant=4'b1000; no cycle has hgrant=0.
REQ-030 Lock scenario: master 2 granted with hbusreq[2]=1, hlock[2]=1, htrans=NONSEQ, then hbusreq[0]=1 -> hgrant stays 4'b0100 and hmastlock=1; after hlock[2]=0, one more hready=1 edge passes, then hgrant=4'b0001.
REQ-031 Wait-state scenario: hready=0 for 3 cycles while hbusreq changes 4'b1000->4'b0001 -> hgrant and hmaster unchanged until hready=1.
REQ-032 Round-robin scenario (ARB_ROUND_ROBIN_EN defined): hbusreq=4'b0011 held, hready=1 -> hgrant alternates 4'b0001, 4'b0010, 4'b0001 on successive edges.
